// File: rtl/bp_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : bp_reg_file
//  Purpose  : Register file addressed over a BytePipe byte stream. A command
//             byte (bit7 = write, bits[6:0] = address) is followed, for
//             writes, by one data byte per burst phase. Every read or write
//             data phase returns one response byte (the pre-write value).
//             Address 0 reads VALUE0 and, when written, loads the burst count.
//  Ports    : i_clk / i_rst     clock, asynchronous active-high reset
//             i_cg              clock gate, all state holds when low
//             i_bp_data/valid   upstream byte stream, o_bp_ready back-pressure
//             o_bp_data/valid   response byte stream, i_bp_ready back-pressure
//             i_hw              hardware-sourced register values
//             o_reg             stored register contents
//             o_wrStrobe        one-cycle pulse per written register
//  Revision : 1.0  initial release
// ============================================================================
module bp_reg_file #(
  parameter int                 N_REG    = 8,
  parameter logic [7:0]         VALUE0   = 8'h00,
  parameter logic [N_REG*8-1:0] WR_MASK  = {N_REG*8{1'b1}},
  parameter logic [N_REG*8-1:0] HW_MASK  = {N_REG*8{1'b0}},
  parameter logic [N_REG*8-1:0] RST_VAL  = {N_REG*8{1'b0}},
  parameter int                 AUTO_INC = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic [7:0]         i_bp_data,
  input  logic               i_bp_valid,
  output logic               o_bp_ready,
  output logic [7:0]         o_bp_data,
  output logic               o_bp_valid,
  input  logic               i_bp_ready,
  input  logic [N_REG*8-1:0] i_hw,
  output logic [N_REG*8-1:0] o_reg,
  output logic [N_REG-1:0]   o_wrStrobe
);

  localparam logic [1:0] ST_CMD    = 2'd0;
  localparam logic [1:0] ST_WDATA  = 2'd1;
  localparam logic [1:0] ST_RBURST = 2'd2;

  localparam logic [6:0] C_LAST_ADDR = 7'(N_REG);

  logic [1:0]         state_q, state_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         burst_q, burst_d;
  logic [N_REG*8-1:0] regs_q, regs_d;
  logic [N_REG-1:0]   strobe_q, strobe_d;
  logic               bp_valid_q, bp_valid_d;
  logic [7:0]         bp_data_q, bp_data_d;

  logic               in_fire;
  logic               out_fire;
  logic               slot_free;
  logic               load;
  logic [6:0]         rd_addr;
  logic [6:0]         step_addr;
  logic [7:0]         rd_val;
  logic [N_REG*8-1:0] merged;

  assign slot_free  = i_cg && (!bp_valid_q || i_bp_ready);
  assign o_bp_ready = (state_q != ST_RBURST) && (!bp_valid_q || i_bp_ready);
  assign in_fire    = i_cg && i_bp_valid && o_bp_ready;
  assign out_fire   = i_cg && bp_valid_q && i_bp_ready;

  assign o_bp_valid = bp_valid_q;
  assign o_bp_data  = bp_data_q;
  assign o_reg      = regs_q;
  assign o_wrStrobe = strobe_q & {N_REG{i_cg}};

  // In CMD the address arrives with the byte being accepted; afterwards it
  // comes from the latched/stepped address.
  assign rd_addr = (state_q == ST_CMD) ? i_bp_data[6:0] : addr_q;
  assign merged  = (regs_q & ~HW_MASK) | (i_hw & HW_MASK);

  always_comb begin
    rd_val = 8'h00;
    if (rd_addr == 7'd0) begin
      rd_val = VALUE0;
    end
    for (int i = 0; i < N_REG; i++) begin
      if (rd_addr == 7'(i + 1)) begin
        rd_val = merged[i*8 +: 8];
      end
    end
  end

  // Burst address step: wraps back to 1 after the last register, and an
  // out-of-range address that rolls over 127 also lands on 1, never 0.
  always_comb begin
    step_addr = rd_addr;
    if (AUTO_INC != 0) begin
      if ((rd_addr == C_LAST_ADDR) || (rd_addr == 7'h7F)) begin
        step_addr = 7'd1;
      end else begin
        step_addr = rd_addr + 7'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CMD: begin
        if (in_fire) begin
          if (i_bp_data[7]) begin
            state_d = ST_WDATA;
          end else if (burst_q > 8'd1) begin
            state_d = ST_RBURST;
          end
        end
      end
      ST_WDATA: begin
        if (in_fire && ((addr_q == 7'd0) || (burst_q <= 8'd1))) begin
          state_d = ST_CMD;
        end
      end
      ST_RBURST: begin
        if (slot_free && (burst_q <= 8'd1)) begin
          state_d = ST_CMD;
        end
      end
      default: state_d = ST_CMD;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    addr_d     = addr_q;
    burst_d    = burst_q;
    regs_d     = regs_q;
    strobe_d   = '0;
    bp_valid_d = bp_valid_q && !out_fire;
    bp_data_d  = bp_data_q;
    load       = 1'b0;
    case (state_q)
      ST_CMD: begin
        if (in_fire) begin
          addr_d = i_bp_data[6:0];
          if (!i_bp_data[7]) begin
            load = 1'b1;
            if (burst_q != 8'd0) begin
              burst_d = burst_q - 8'd1;
              addr_d  = step_addr;
            end
          end
        end
      end
      ST_WDATA: begin
        if (in_fire) begin
          load = 1'b1;
          for (int i = 0; i < N_REG; i++) begin
            if (addr_q == 7'(i + 1)) begin
              regs_d[i*8 +: 8] = (regs_q[i*8 +: 8] & ~WR_MASK[i*8 +: 8]) |
                                 (i_bp_data & WR_MASK[i*8 +: 8]);
              strobe_d[i]      = 1'b1;
            end
          end
          // Address 0 loads the burst count and never consumes a burst.
          if (addr_q == 7'd0) begin
            burst_d = i_bp_data;
          end else if (burst_q != 8'd0) begin
            burst_d = burst_q - 8'd1;
            addr_d  = step_addr;
          end
        end
      end
      ST_RBURST: begin
        if (slot_free) begin
          load    = 1'b1;
          burst_d = burst_q - 8'd1;
          addr_d  = step_addr;
        end
      end
      default: ;
    endcase
    if (load) begin
      bp_valid_d = 1'b1;
      bp_data_d  = rd_val;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q     <= 7'd0;
      burst_q    <= 8'd0;
      regs_q     <= RST_VAL;
      strobe_q   <= '0;
      bp_valid_q <= 1'b0;
      bp_data_q  <= 8'h00;
    end else begin
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      regs_q     <= regs_d;
      strobe_q   <= strobe_d;
      bp_valid_q <= bp_valid_d;
      bp_data_q  <= bp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_reg_file
//  Purpose  : Self-checking bench for bp_reg_file. Two instances share one
//             input stream: dut0 auto-increments burst addresses, dut1 does
//             not. Expected response bytes are queued per instance by the
//             stimulus and popped by a monitor on each accepted output beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_reg_file;

  localparam int          N_REG = 8;
  localparam logic [63:0] RST_V = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h0C};
  localparam logic [63:0] WR_M  = {56'hFF_FFFF_FFFF_FFFF, 8'h0F};
  localparam logic [63:0] HW_M  = {56'h0, 8'hF0};

  logic        clk, rst, cg;
  logic [7:0]  bp_data;
  logic        bp_valid, dn_rdy;
  logic [63:0] hw;

  logic        rdy0, vld0, rdy1, vld1;
  logic [7:0]  dat0, dat1, stb0, stb1;
  logic [63:0] reg0, reg1;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic        toggle_en;

  bp_reg_file #(.N_REG(N_REG), .VALUE0(8'h00), .WR_MASK(WR_M), .HW_MASK(HW_M),
                .RST_VAL(RST_V), .AUTO_INC(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_bp_data(bp_data), .i_bp_valid(bp_valid),
    .o_bp_ready(rdy0), .o_bp_data(dat0), .o_bp_valid(vld0), .i_bp_ready(dn_rdy),
    .i_hw(hw), .o_reg(reg0), .o_wrStrobe(stb0));

  bp_reg_file #(.N_REG(N_REG), .VALUE0(8'h00), .WR_MASK(WR_M), .HW_MASK(HW_M),
                .RST_VAL(RST_V), .AUTO_INC(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_bp_data(bp_data), .i_bp_valid(bp_valid),
    .o_bp_ready(rdy1), .o_bp_data(dat1), .o_bp_valid(vld1), .i_bp_ready(dn_rdy),
    .i_hw(hw), .o_reg(reg1), .o_wrStrobe(stb1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: a beat is consumed at the next rising edge when
  // valid, downstream ready and the clock gate are all high.
  always @(negedge clk) begin
    if (!rst && cg && vld0 && dn_rdy) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_resp: got %h expected none", dat0);
      end else begin
        chk("dut0_resp", 64'(dat0), 64'(q0.pop_front()));
      end
    end
    if (!rst && cg && vld1 && dn_rdy) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_resp: got %h expected none", dat1);
      end else begin
        chk("dut1_resp", 64'(dat1), 64'(q1.pop_front()));
      end
    end
    if (!rst && vld0 && !dn_rdy) begin
      chk("dut0_ready_while_pending", 64'(rdy0), 64'd0);
    end
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1 dn_rdy = ~dn_rdy;
    end
  end

  task automatic push(input logic [7:0] e0, input logic [7:0] e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Present one byte and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    bp_valid = 1'b1;
    bp_data  = b;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rdy0) begin
      checks++; failures++;
      $display("FAIL send_timeout: ready %b expected 1", rdy0);
    end
    @(posedge clk);
    #1 bp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_outstanding", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; bp_valid = 1'b0; bp_data = 8'h00;
    dn_rdy = 1'b1; hw = '0; toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  64'(vld0), 64'd0);
    chk("rst_data",   64'(dat0), 64'd0);
    chk("rst_reg0",   reg0, RST_V);
    chk("rst_reg1",   reg1, RST_V);
    chk("rst_strobe", 64'(stb0), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Plain reads: magic, register 1, out of range
    push(8'h00, 8'h00); send(8'h00);
    push(8'h0C, 8'h0C); send(8'h01);
    push(8'h00, 8'h00); send(8'h7F);
    drain();

    // Masked write to register 1, response is the old value
    push(8'h0C, 8'h0C);
    send(8'h81);
    send(8'hA5);
    chk("wr_reg1_dut0",   64'(reg0[7:0]), 64'h05);
    chk("wr_reg1_dut1",   64'(reg1[7:0]), 64'h05);
    chk("wr_strobe_dut0", 64'(stb0), 64'h01);
    chk("wr_strobe_dut1", 64'(stb1), 64'h01);
    chk("wr_resp_valid",  64'(vld0), 64'd1);
    @(posedge clk); #1;
    chk("wr_strobe_pulse", 64'(stb0), 64'h00);
    drain();

    // Hardware-sourced upper nibble
    hw[7:0] = 8'h30;
    push(8'h35, 8'h35); send(8'h01);
    drain();

    // Burst of 3 reads from address 7
    push(8'h00, 8'h00); send(8'h80); send(8'h03);
    chk("burst_wr_no_strobe", 64'(stb0), 64'h00);
    drain();
    q0.push_back(8'h77); q0.push_back(8'h88); q0.push_back(8'h35);
    q1.push_back(8'h77); q1.push_back(8'h77); q1.push_back(8'h77);
    send(8'h07);
    chk("rburst_ready_dut0", 64'(rdy0), 64'd0);
    chk("rburst_ready_dut1", 64'(rdy1), 64'd0);
    drain();
    push(8'h22, 8'h22); send(8'h02);
    drain();

    // Burst of 2 writes to address 2 with toggling downstream ready
    push(8'h00, 8'h00); send(8'h80); send(8'h02);
    drain();
    toggle_en = 1'b1;
    push(8'h22, 8'h22);
    push(8'h33, 8'hA1);
    send(8'h82);
    send(8'hA1);
    send(8'hB2);
    drain();
    toggle_en = 1'b0;
    @(posedge clk); #2 dn_rdy = 1'b1;
    chk("bw_dut0_reg2", 64'(reg0[15:8]),  64'hA1);
    chk("bw_dut0_reg3", 64'(reg0[23:16]), 64'hB2);
    chk("bw_dut1_reg2", 64'(reg1[15:8]),  64'hB2);
    chk("bw_dut1_reg3", 64'(reg1[23:16]), 64'h33);
    push(8'hA1, 8'hB2); send(8'h02);
    drain();

    // Clock gate low holds a pending response
    dn_rdy = 1'b0;
    push(8'h44, 8'h44);
    send(8'h04);
    @(posedge clk); #1;
    cg = 1'b0; dn_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("cg_hold_valid", 64'(vld0), 64'd1);
    chk("cg_hold_data",  64'(dat0), 64'h44);
    cg = 1'b1;
    drain();

    // Reset in the middle of a write
    hw = '0;
    send(8'h82);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid",  64'(vld0), 64'd0);
    chk("midrst_reg0",   reg0, RST_V);
    chk("midrst_reg1",   reg1, RST_V);
    chk("midrst_strobe", 64'(stb0), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    push(8'h0C, 8'h0C); send(8'h01);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
